// File: rtl/cic_decim_param.sv
// cic_decim_param -- parameterised CIC decimator for 1-bit sigma-delta bitstreams.
//
// ORDER integrators run on every enabled modulator clock. A decimation strobe
// fires every 2^L clocks and launches the newest integrator value through
// ORDER comb stages. Each comb stage does one stage per clock. For very short
// ratios (D < ORDER+1) the comb stages instead evaluate in the strobe cycle.
// The comb result is scaled to OUT_W bits, saturated, and held in an output
// register behind a valid/ready handshake.
//
// Ports:
//   clk        modulator clock, all logic on posedge
//   reset      asynchronous active-high reset
//   in         modulator bitstream
//   enable     run the filter; low flushes the filter state
//   dec_sel    log2 of the decimation ratio, captured when a run starts
//   bipolar    1: bit codes as +1/-1, 0: bit codes as 1/0
//   out_data   filtered sample, two's complement
//   out_valid  out_data holds an unconsumed sample
//   out_ready  consumer accepts the sample
//   sat        the current sample was clamped
//   overrun    one-cycle pulse when an unconsumed sample is overwritten
//
// Optional build macro CIC_DECIM_MON_EN adds a state monitor:
//   mon_sel    0..ORDER-1 integrator k, ORDER..2*ORDER-1 comb delay register
//   mon_data   selected value, registered (1 clk latency)
module cic_decim_param #(
  parameter int ORDER        = 3,
  parameter int MAX_LOG2_DEC = 8,
  parameter int OUT_W        = 16,
  localparam int ACC_W       = ORDER * MAX_LOG2_DEC + 2,
  localparam int SEL_W       = $clog2(MAX_LOG2_DEC + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             enable,
  input  logic [SEL_W-1:0] dec_sel,
  input  logic             bipolar,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat,
  output logic             overrun
`ifdef CIC_DECIM_MON_EN
  ,
  input  logic [$clog2(2*ORDER)-1:0] mon_sel,
  output logic [ACC_W-1:0]           mon_data
`endif
);

  localparam int W_EXT  = ACC_W + OUT_W;        // headroom for the left-shift case
  localparam int L_COMB = $clog2(ORDER + 1);    // L below this means D < ORDER+1
  localparam int WARM_W = $clog2(ORDER + 1);    // holds a strobe count of 0..ORDER
  localparam logic signed [W_EXT-1:0] MAX_V = W_EXT'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [W_EXT-1:0] MIN_V = ~MAX_V;

  function automatic logic [SEL_W-1:0] clamp_dec_sel(input logic [SEL_W-1:0] sel);
    if (sel > SEL_W'(MAX_LOG2_DEC)) begin
      return SEL_W'(MAX_LOG2_DEC);
    end else begin
      return sel;
    end
  endfunction

  logic                    en_q_r;
  logic [SEL_W-1:0]        l_q_r;
  logic [MAX_LOG2_DEC-1:0] cnt_r;
  logic [WARM_W-1:0]       warm_r;

  logic                    start_s;
  logic [SEL_W-1:0]        l_eff_s;
  logic [MAX_LOG2_DEC-1:0] mask_s;
  logic                    strobe_s;
  logic                    comb_mode_s;
  logic                    emit_now_s;
  logic [ACC_W-1:0]        code_s;
  logic [ACC_W-1:0]        acc_last_s;
  logic [ACC_W-1:0]        result_s;
  logic                    load_s;

  // The first enabled cycle uses the freshly captured ratio so the counter
  // and comb mode are consistent from the very first clock of a run.
  assign start_s     = enable & ~en_q_r;
  assign l_eff_s     = start_s ? clamp_dec_sel(dec_sel) : l_q_r;
  assign mask_s      = ~({MAX_LOG2_DEC{1'b1}} << l_eff_s);
  assign strobe_s    = enable & (cnt_r == mask_s);
  assign comb_mode_s = (l_eff_s < SEL_W'(L_COMB));
  assign emit_now_s  = strobe_s & (warm_r == WARM_W'(ORDER));
  assign code_s      = in ? ACC_W'(1) : (bipolar ? {ACC_W{1'b1}} : {ACC_W{1'b0}});

  // run-start detection and decimation ratio capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q_r <= 1'b0;
      l_q_r  <= {SEL_W{1'b0}};
    end else begin
      en_q_r <= enable;
      l_q_r  <= l_eff_s;
    end
  end

  // decimation counter and warm-up strobe count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= {MAX_LOG2_DEC{1'b0}};
      warm_r <= {WARM_W{1'b0}};
    end else if (!enable) begin
      cnt_r  <= {MAX_LOG2_DEC{1'b0}};
      warm_r <= {WARM_W{1'b0}};
    end else begin
      cnt_r <= strobe_s ? {MAX_LOG2_DEC{1'b0}} : cnt_r + MAX_LOG2_DEC'(1);
      if (strobe_s && (warm_r != WARM_W'(ORDER))) begin
        warm_r <= warm_r + WARM_W'(1);
      end
    end
  end

  for (genvar k = 0; k < ORDER; k++) begin : g_stg
    logic [ACC_W-1:0] acc_r;    // integrator k (wraps modulo 2^ACC_W)
    logic [ACC_W-1:0] x_r;      // comb k input latched while the token waits here
    logic [ACC_W-1:0] prev_r;   // comb k delay element
    logic             tok_r;    // token is at comb stage k this cycle
    logic             emit_r;   // token carries a sample past warm-up
    logic [ACC_W-1:0] up_s;
    logic [ACC_W-1:0] in_s;
    logic [ACC_W-1:0] d_s;
    logic [ACC_W-1:0] x_in_s;
    logic             tok_in_s;
    logic             emit_in_s;
    logic             upd_s;

    if (k == 0) begin : g_first
      assign up_s      = code_s;
      assign in_s      = comb_mode_s ? acc_last_s : x_r;
      assign x_in_s    = acc_last_s;
      assign tok_in_s  = strobe_s & ~comb_mode_s;
      assign emit_in_s = emit_now_s;
    end else begin : g_next
      assign up_s      = g_stg[k-1].acc_r;
      assign in_s      = comb_mode_s ? g_stg[k-1].d_s : x_r;
      assign x_in_s    = g_stg[k-1].d_s;
      assign tok_in_s  = g_stg[k-1].tok_r;
      assign emit_in_s = g_stg[k-1].emit_r;
    end

    assign d_s   = in_s - prev_r;
    assign upd_s = comb_mode_s ? strobe_s : tok_r;

    // integrator k, comb k delay element and token pipeline register
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc_r  <= {ACC_W{1'b0}};
        x_r    <= {ACC_W{1'b0}};
        prev_r <= {ACC_W{1'b0}};
        tok_r  <= 1'b0;
        emit_r <= 1'b0;
      end else if (!enable) begin
        acc_r  <= {ACC_W{1'b0}};
        x_r    <= {ACC_W{1'b0}};
        prev_r <= {ACC_W{1'b0}};
        tok_r  <= 1'b0;
        emit_r <= 1'b0;
      end else begin
        acc_r <= acc_r + up_s;
        if (upd_s) begin
          prev_r <= in_s;
        end
        if (tok_in_s) begin
          x_r <= x_in_s;
        end
        tok_r  <= tok_in_s;
        emit_r <= tok_in_s & emit_in_s;
      end
    end
  end

  // The last comb stage produces the result in both the pipelined and the
  // same-cycle mode; only the load condition differs.
  assign acc_last_s = g_stg[ORDER-1].acc_r;
  assign result_s   = g_stg[ORDER-1].d_s;
  assign load_s     = enable & (comb_mode_s ? emit_now_s
                                            : (g_stg[ORDER-1].tok_r & g_stg[ORDER-1].emit_r));

  logic signed [W_EXT-1:0] wide_s;
  logic signed [W_EXT-1:0] scaled_s;
  logic        [7:0]       prod_s;
  logic signed [7:0]       shift_s;
  logic        [7:0]       sh_amt_s;
  logic        [OUT_W-1:0] sample_s;
  logic                    sat_s;

  // scale by 2^-(ORDER*L-(OUT_W-1)) with floor on right shifts, then clamp
  always_comb begin
    wide_s   = {{OUT_W{result_s[ACC_W-1]}}, result_s};
    prod_s   = 8'(ORDER) * 8'(l_q_r);
    shift_s  = prod_s - 8'(OUT_W - 1);
    sh_amt_s = shift_s[7] ? (8'd0 - shift_s) : shift_s;
    if (shift_s[7]) begin
      scaled_s = wide_s <<< sh_amt_s;
    end else begin
      scaled_s = wide_s >>> sh_amt_s;
    end
    if (scaled_s > MAX_V) begin
      sample_s = MAX_V[OUT_W-1:0];
      sat_s    = 1'b1;
    end else if (scaled_s < MIN_V) begin
      sample_s = MIN_V[OUT_W-1:0];
      sat_s    = 1'b1;
    end else begin
      sample_s = scaled_s[OUT_W-1:0];
      sat_s    = 1'b0;
    end
  end

  // output holding register: valid/ready handshake, overwrite flags overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= {OUT_W{1'b0}};
      out_valid <= 1'b0;
      sat       <= 1'b0;
      overrun   <= 1'b0;
    end else if (load_s) begin
      out_data  <= sample_s;
      sat       <= sat_s;
      out_valid <= 1'b1;
      overrun   <= out_valid & ~out_ready;
    end else begin
      overrun <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CIC_DECIM_MON_EN
  logic [ACC_W-1:0] mon_acc_s  [ORDER];
  logic [ACC_W-1:0] mon_comb_s [ORDER];
  logic [ACC_W-1:0] mon_pick_s;

  for (genvar k = 0; k < ORDER; k++) begin : g_mon
    assign mon_acc_s[k]  = g_stg[k].acc_r;
    assign mon_comb_s[k] = g_stg[k].prev_r;
  end

  // monitor select; indices past 2*ORDER-1 match nothing and read as zero
  always_comb begin
    mon_pick_s = {ACC_W{1'b0}};
    for (int i = 0; i < ORDER; i++) begin
      mon_pick_s = mon_pick_s
                 | ((mon_sel == $clog2(2*ORDER)'(i)) ? mon_acc_s[i] : {ACC_W{1'b0}})
                 | ((mon_sel == $clog2(2*ORDER)'(i + ORDER)) ? mon_comb_s[i] : {ACC_W{1'b0}});
    end
  end

  // registered monitor output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mon_data <= {ACC_W{1'b0}};
    end else begin
      mon_data <= mon_pick_s;
    end
  end
`endif

endmodule

// File: tb/tb_cic_decim_param.sv
module tb_cic_decim_param;
  localparam int ORDER        = 3;
  localparam int MAX_LOG2_DEC = 8;
  localparam int OUT_W        = 16;
  localparam int SEL_W        = $clog2(MAX_LOG2_DEC + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in = 1'b0;
  logic             enable = 1'b0;
  logic [SEL_W-1:0] dec_sel = '0;
  logic             bipolar = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             sat;
  logic             overrun;

  cic_decim_param #(.ORDER(ORDER), .MAX_LOG2_DEC(MAX_LOG2_DEC), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .in(in), .enable(enable), .dec_sel(dec_sel),
    .bipolar(bipolar), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sat(sat), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int     due;   // edge number at which the sample must be loaded
    longint data;
    bit     sat;
  } exp_t;
  exp_t exp_q[$];

  // reference model state: unbounded integer arithmetic, no wrap-around
  longint m_acc[ORDER];
  longint m_prev[ORDER];
  int     m_cnt;
  int     m_strobes;
  int     m_L;
  bit     m_en;

  task automatic check(input string name, input logic signed [63:0] act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < ORDER; j++) begin
      m_acc[j]  = 0;
      m_prev[j] = 0;
    end
    m_cnt     = 0;
    m_strobes = 0;
    m_en      = 1'b0;
  endtask

  task automatic scale(input longint v, input int L, output longint y, output bit s);
    int     sh;
    longint t;
    longint maxv;
    sh   = ORDER * L - (OUT_W - 1);
    t    = (sh >= 0) ? (v >>> sh) : (v <<< (-sh));
    maxv = (longint'(1) <<< (OUT_W - 1)) - 1;
    s    = 1'b0;
    y    = t;
    if (t > maxv) begin y = maxv; s = 1'b1; end
    if (t < -maxv - 1) begin y = -maxv - 1; s = 1'b1; end
  endtask

  // one input cycle; these inputs are sampled by edge cyc+1
  task automatic model_cycle(input bit e, input bit i, input bit b, input int d);
    int     dd;
    longint v;
    longint t;
    exp_t   it;
    if (!e) begin
      model_clear();
      while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
    end else begin
      if (!m_en) m_L = (d > MAX_LOG2_DEC) ? MAX_LOG2_DEC : d;
      dd = 1 << m_L;
      if (m_cnt == dd - 1) begin
        v = m_acc[ORDER-1];
        for (int j = 0; j < ORDER; j++) begin
          t = v - m_prev[j];
          m_prev[j] = v;
          v = t;
        end
        if (m_strobes >= ORDER) begin
          it.due = cyc + 1 + ((dd < ORDER + 1) ? 0 : ORDER);
          scale(v, m_L, it.data, it.sat);
          exp_q.push_back(it);
        end
        m_strobes++;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      for (int j = ORDER - 1; j >= 1; j--) m_acc[j] += m_acc[j-1];
      m_acc[0] += i ? 1 : (b ? -1 : 0);
      m_en = 1'b1;
    end
  endtask

  task automatic step(input bit e, input bit i, input bit b, input int d, input bit r);
    enable    = e;
    in        = i;
    bipolar   = b;
    dec_sel   = SEL_W'(d);
    out_ready = r;
    model_cycle(e, i, b, d);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  // monitor: pops expected samples at their load edge and tracks the handshake
  initial begin : monitor
    bit     mv;
    bit     rdy;
    bit     load;
    bit     exp_ov;
    longint md;
    bit     ms;
    exp_t   it;
    mv = 1'b0; md = 0; ms = 1'b0;
    forever begin
      @(posedge clk);
      rdy = out_ready;
      #1;
      exp_ov = 1'b0;
      if (reset) begin
        mv = 1'b0;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          it = exp_q.pop_front();
          check("missed_sample_edge", cyc, it.due);
        end
        load = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          it = exp_q.pop_front();
          load = 1'b1;
        end
        exp_ov = load && mv && !rdy;
        if (load) begin
          mv = 1'b1; md = it.data; ms = it.sat;
        end else if (mv && rdy) begin
          mv = 1'b0;
        end
      end
      check("out_valid", out_valid, mv);
      check("overrun", overrun, exp_ov);
      if (mv) begin
        check("out_data", $signed(out_data), md);
        check("sat", sat, ms);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int d;
    int len;
    model_clear();
    repeat (3) @(posedge clk);
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", $signed(out_data), 0);
    check("reset_sat", sat, 0);
    check("reset_overrun", overrun, 0);
    reset = 1'b0;

    // unipolar full scale, D=256: clamps to 32767
    for (int n = 0; n < 6 * 256; n++) step(1'b1, 1'b1, 1'b0, 8, 1'b1);
    idle(3);
    // bipolar all zeros: exactly -32768, no clamp
    for (int n = 0; n < 6 * 256; n++) step(1'b1, 1'b0, 1'b1, 8, 1'b1);
    idle(3);
    // bipolar alternating: zero output
    for (int n = 0; n < 6 * 256; n++) step(1'b1, (n % 2) == 0, 1'b1, 8, 1'b1);
    idle(3);
    // unipolar quarter density, D=16: 8192; long enough for integrator wrap
    for (int n = 0; n < 3000; n++) step(1'b1, (n % 4) == 0, 1'b0, 4, 1'b1);
    idle(3);
    // consumer stalls across several sample periods
    for (int n = 0; n < 2000; n++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 4, (n % 48) >= 40);
    idle(3);
    // short ratios take the same-cycle comb path
    for (int n = 0; n < 200; n++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1, 1'($urandom_range(0, 1)));
    idle(2);
    for (int n = 0; n < 100; n++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 0, 1'($urandom_range(0, 1)));
    idle(2);
    // out-of-range ratio clamps to the maximum
    for (int n = 0; n < 6 * 256; n++) step(1'b1, 1'b1, 1'b0, 12, 1'b1);
    idle(2);
    // ratio change mid-run is ignored
    for (int n = 0; n < 400; n++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, (n < 50) ? 4 : 2, 1'b1);
    idle(2);
    // enable drop mid-sample keeps the pending output, next run warms up again
    for (int n = 0; n < 100; n++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 4, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4, 1'b0);
    for (int n = 0; n < 150; n++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 4, 1'($urandom_range(0, 1)));
    idle(2);

    // randomized runs
    for (int r = 0; r < 20; r++) begin
      d   = $urandom_range(0, 10);
      len = (ORDER + 3) * (1 << ((d > MAX_LOG2_DEC) ? MAX_LOG2_DEC : d)) + $urandom_range(0, 40);
      for (int n = 0; n < len; n++)
        step(1'b1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), d, ($urandom_range(0, 3) != 0));
      idle($urandom_range(1, 3));
    end

    // asynchronous reset mid-run clears outputs immediately
    for (int n = 0; n < 120; n++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 4, 1'b0);
    reset = 1'b1;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_out_data", $signed(out_data), 0);
    check("midreset_sat", sat, 0);
    check("midreset_overrun", overrun, 0);
    model_clear();
    exp_q.delete();
    step(1'b0, 1'b0, 1'b0, 4, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4, 1'b1);
    reset = 1'b0;
    for (int n = 0; n < 150; n++) step(1'b1, 1'b1, 1'b0, 4, 1'b1);
    idle(ORDER + 4);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
